// File: rtl/sd_emmc_data_rx.sv
`default_nettype none
// ============================================================================
// Module   : sd_emmc_data_rx
// Purpose  : SD/eMMC block-read data receiver (sd_clk domain). Detects the
//            start bit on the active DAT lanes, deserialises 1/4/8-bit data
//            MSB first, packs bytes little-endian into 32-bit FIFO words,
//            checks a CRC16-CCITT per active lane and the end bit, and loops
//            over the requested number of blocks.
// Ports    : sd_clk, rst (async, active high)
//            start_i / abort_i         - transfer control pulses
//            bus_width_i, blk_size_i,
//            blk_cnt_i, timeout_i      - transfer setup, latched on start_i
//            dat_i                     - DAT[7:0], already synchronised
//            fifo_full_i / fifo_wr_en_o / fifo_data_o - FIFO write side
//            busy_o, done_o            - transfer status
//            crc_err_o, end_err_o,
//            tout_err_o, ovr_err_o     - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module sd_emmc_data_rx #(
  parameter int BLKSZ_W  = 12,
  parameter int BLKCNT_W = 16,
  parameter int TOUT_W   = 24
) (
  input  logic                sd_clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [1:0]          bus_width_i,
  input  logic [BLKSZ_W-1:0]  blk_size_i,
  input  logic [BLKCNT_W-1:0] blk_cnt_i,
  input  logic [TOUT_W-1:0]   timeout_i,
  input  logic [7:0]          dat_i,
  input  logic                fifo_full_i,
  output logic                fifo_wr_en_o,
  output logic [31:0]         fifo_data_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                crc_err_o,
  output logic                end_err_o,
  output logic                tout_err_o,
  output logic                ovr_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CRC   = 3'd3;
  localparam logic [2:0] S_END   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]          state;
  logic [2:0]          next_state;

  logic [1:0]          width_q;
  logic [BLKSZ_W-1:0]  blk_size_q;
  logic [TOUT_W-1:0]   timeout_q;
  logic [TOUT_W-1:0]   wait_cnt;
  logic [BLKSZ_W:0]    byte_rem;
  logic [BLKCNT_W:0]   blk_rem;
  logic [2:0]          bit_cnt;
  logic [1:0]          byte_idx;
  logic [3:0]          crc_cnt;
  logic [7:0]          shift_byte;
  logic [31:0]         word;
  logic                wr_pend;

  logic [7:0]          lane_mask;
  logic [7:0]          next_shift;
  logic [2:0]          last_bit_pos;
  logic [BLKSZ_W:0]    byte_init;
  logic                hold;
  logic                start_bit;
  logic                end_ok;
  logic                byte_done;
  logic                last_byte;
  logic                timed_out;
  logic                crc_ok;
  logic                crc_clr;
  logic                crc_en;
  logic [7:0]          lane_zero;

  // abort only matters once a transfer is running; in IDLE start_i wins
  assign hold = abort_i && (state != S_IDLE);

  always_comb begin
    lane_mask    = 8'h01;
    last_bit_pos = 3'd7;
    next_shift   = {shift_byte[6:0], dat_i[0]};
    case (width_q)
      2'b01: begin
        lane_mask    = 8'h0F;
        last_bit_pos = 3'd1;
        next_shift   = {shift_byte[3:0], dat_i[3:0]};
      end
      2'b10: begin
        lane_mask    = 8'hFF;
        last_bit_pos = 3'd0;
        next_shift   = dat_i;
      end
      default: ;
    endcase
  end

  // zero block size means 2^BLKSZ_W bytes (natural wrap of the counter)
  assign byte_init = (blk_size_q == '0) ? {1'b1, {BLKSZ_W{1'b0}}}
                                        : {1'b0, blk_size_q};

  assign start_bit = ((dat_i & lane_mask) == 8'h00);
  assign end_ok    = ((dat_i & lane_mask) == lane_mask);
  assign byte_done = (state == S_DATA) && (bit_cnt == last_bit_pos);
  assign last_byte = byte_done && (byte_rem == {{BLKSZ_W{1'b0}}, 1'b1});
  assign timed_out = (state == S_WAIT) && !start_bit && (wait_cnt == timeout_q);
  assign crc_clr   = !hold && (state == S_WAIT) && start_bit;
  assign crc_en    = !hold && ((state == S_DATA) || (state == S_CRC));
  assign crc_ok    = ((lane_zero | ~lane_mask) == 8'hFF);

  // Per-lane CRC16-CCITT. The received CRC is shifted through the same
  // register, so a good block leaves a zero remainder at the end bit.
  for (genvar l = 0; l < 8; l++) begin : g_lane
    logic [15:0] crc_q;
    logic        fb;
    assign fb = crc_q[15] ^ dat_i[l];
    always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) begin
        crc_q <= 16'h0000;
      end else if (crc_clr) begin
        crc_q <= 16'h0000;
      end else if (crc_en) begin
        crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    assign lane_zero[l] = (crc_q == 16'h0000);
  end

  // state register
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start_i) next_state = S_WAIT;
      S_WAIT: begin
        if (start_bit)      next_state = S_DATA;
        else if (timed_out) next_state = S_DONE;
      end
      S_DATA: if (last_byte) next_state = S_CRC;
      S_CRC:  if (crc_cnt == 4'd15) next_state = S_END;
      S_END:  next_state = (blk_rem == {{BLKCNT_W{1'b0}}, 1'b1}) ? S_DONE : S_WAIT;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (hold) next_state = S_IDLE;
  end

  // outputs
  always_comb begin
    busy_o       = (state != S_IDLE) && (state != S_DONE);
    done_o       = (state == S_DONE) && !abort_i;
    fifo_wr_en_o = wr_pend && !fifo_full_i && !hold;
  end

  assign fifo_data_o = word;

  // datapath, counters and sticky errors
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      width_q    <= '0;
      blk_size_q <= '0;
      timeout_q  <= '0;
      wait_cnt   <= '0;
      byte_rem   <= '0;
      blk_rem    <= '0;
      bit_cnt    <= '0;
      byte_idx   <= '0;
      crc_cnt    <= '0;
      shift_byte <= '0;
      word       <= '0;
      wr_pend    <= 1'b0;
      crc_err_o  <= 1'b0;
      end_err_o  <= 1'b0;
      tout_err_o <= 1'b0;
      ovr_err_o  <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      // the completed word is dropped, reception continues
      if (wr_pend && fifo_full_i && !hold) ovr_err_o <= 1'b1;
      if (!hold) begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              width_q    <= bus_width_i;
              blk_size_q <= blk_size_i;
              timeout_q  <= timeout_i;
              blk_rem    <= (blk_cnt_i == '0) ? {1'b1, {BLKCNT_W{1'b0}}}
                                              : {1'b0, blk_cnt_i};
              wait_cnt   <= '0;
              crc_err_o  <= 1'b0;
              end_err_o  <= 1'b0;
              tout_err_o <= 1'b0;
              ovr_err_o  <= 1'b0;
            end
          end
          S_WAIT: begin
            if (start_bit) begin
              byte_rem <= byte_init;
              bit_cnt  <= '0;
              byte_idx <= '0;
              crc_cnt  <= '0;
            end else if (wait_cnt == timeout_q) begin
              tout_err_o <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_DATA: begin
            shift_byte <= next_shift;
            if (byte_done) begin
              bit_cnt                <= '0;
              word[8*byte_idx +: 8]  <= next_shift;
              byte_idx               <= byte_idx + 1'b1;
              byte_rem               <= byte_rem - 1'b1;
              if (byte_idx == 2'd3) wr_pend <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_CRC: crc_cnt <= crc_cnt + 1'b1;
          S_END: begin
            if (!end_ok) end_err_o <= 1'b1;
            if (!crc_ok) crc_err_o <= 1'b1;
            blk_rem  <= blk_rem - 1'b1;
            wait_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sd_emmc_data_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_emmc_data_rx
// Purpose  : Directed scoreboard bench for sd_emmc_data_rx. Stimulus tasks
//            serialise blocks onto DAT (with model-generated CRC16) and push
//            the expected FIFO words; a monitor pops and compares each write.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_emmc_data_rx;

  logic        sd_clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [1:0]  bus_width_i = 2'b00;
  logic [11:0] blk_size_i = '0;
  logic [15:0] blk_cnt_i = '0;
  logic [23:0] timeout_i = '0;
  logic [7:0]  dat_i = 8'hFF;
  logic        fifo_full_i = 1'b0;
  logic        fifo_wr_en_o;
  logic [31:0] fifo_data_o;
  logic        busy_o, done_o, crc_err_o, end_err_o, tout_err_o, ovr_err_o;

  always #5 sd_clk = ~sd_clk;

  sd_emmc_data_rx #(.BLKSZ_W(12), .BLKCNT_W(16), .TOUT_W(24)) dut (
    .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .bus_width_i(bus_width_i), .blk_size_i(blk_size_i), .blk_cnt_i(blk_cnt_i),
    .timeout_i(timeout_i), .dat_i(dat_i), .fifo_full_i(fifo_full_i),
    .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o), .busy_o(busy_o),
    .done_o(done_o), .crc_err_o(crc_err_o), .end_err_o(end_err_o),
    .tout_err_o(tout_err_o), .ovr_err_o(ovr_err_o)
  );

  int          checks = 0;
  int          passes = 0;
  logic [31:0] sb[$];
  int          wr_count = 0;
  int          done_count = 0;
  int          base_wr = 0;
  int          base_done = 0;
  logic [31:0] first_word = '0;
  bit          got_first = 1'b0;
  logic        next_full = 1'b0;
  logic [7:0]  blk_data [2048];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // monitor / scoreboard
  always @(negedge sd_clk) begin
    if (!rst) begin
      if (done_o) done_count++;
      if (fifo_wr_en_o) begin
        wr_count++;
        if (!got_first) begin
          first_word = fifo_data_o;
          got_first  = 1'b1;
        end
        if (sb.size() == 0) check("unexpected_write", {31'd0, fifo_wr_en_o}, 32'd0);
        else check("fifo_data", fifo_data_o, sb.pop_front());
      end
    end
  end

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d);
    dat_i       = d;
    fifo_full_i = next_full;
    next_full   = 1'b0;
    tick();
  endtask

  task automatic start_xfer(input logic [1:0] w, input int size, input int cnt, input int tout);
    bus_width_i = w;
    blk_size_i  = 12'(size);
    blk_cnt_i   = 16'(cnt);
    timeout_i   = 24'(tout);
    base_wr     = wr_count;
    base_done   = done_count;
    got_first   = 1'b0;
    start_i     = 1'b1;
    drive(8'hFF);
    start_i     = 1'b0;
  endtask

  // w: 0=1-bit 1=4-bit 2=8-bit; full_word: word index to drop with FIFO full;
  // stop_crc: return before that CRC cycle (no end bit), -1 for full block
  task automatic send_block(input int w, input int nbytes, input int gap, input bit flip,
                            input int full_word, input int stop_crc);
    int          nl, ncyc;
    logic [15:0] lc [8];
    logic [7:0]  d, b, mask;
    logic [31:0] wd;
    nl   = (w == 1) ? 4 : (w == 2) ? 8 : 1;
    mask = 8'((1 << nl) - 1);
    ncyc = (w == 0) ? 8 : (w == 1) ? 2 : 1;
    wd   = '0;
    for (int l = 0; l < 8; l++) lc[l] = 16'h0;
    for (int i = 0; i < gap; i++) drive(8'hFF);
    drive(~mask);
    for (int n = 0; n < nbytes; n++) begin
      b = blk_data[n];
      wd[8*(n%4) +: 8] = b;
      for (int c = 0; c < ncyc; c++) begin
        if (w == 0)      d = {7'h7F, b[7-c]};
        else if (w == 1) d = {4'hF, (c == 0) ? b[7:4] : b[3:0]};
        else             d = b;
        for (int l = 0; l < nl; l++) lc[l] = crc_step(lc[l], d[l]);
        drive(d);
      end
      if (n % 4 == 3) begin
        if (n / 4 == full_word) next_full = 1'b1;
        else sb.push_back(wd);
      end
    end
    for (int i = 0; i < 16; i++) begin
      if (i == stop_crc) return;
      d = 8'hFF;
      for (int l = 0; l < nl; l++) d[l] = lc[l][15-i];
      if (flip && i == 15) d[0] = ~d[0];
      drive(d);
    end
    drive(8'hFF);
  endtask

  task automatic check_xfer(input string nm, input int exp_wr, input int exp_done,
                            input bit ce, input bit ee, input bit te, input bit oe);
    repeat (3) drive(8'hFF);
    check({nm, "_writes"}, 32'(wr_count - base_wr), 32'(exp_wr));
    check({nm, "_done"}, 32'(done_count - base_done), 32'(exp_done));
    check({nm, "_crc_err"}, {31'd0, crc_err_o}, {31'd0, ce});
    check({nm, "_end_err"}, {31'd0, end_err_o}, {31'd0, ee});
    check({nm, "_tout_err"}, {31'd0, tout_err_o}, {31'd0, te});
    check({nm, "_ovr_err"}, {31'd0, ovr_err_o}, {31'd0, oe});
    check({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
    check({nm, "_busy"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic run_case1(input string nm);
    for (int i = 0; i < 512; i++) blk_data[i] = 8'(i);
    start_xfer(2'b01, 512, 1, 1000);
    send_block(1, 512, 2, 1'b0, -1, -1);
    check_xfer(nm, 128, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    check({nm, "_word0"}, first_word, 32'h03020100);
  endtask

  initial begin
    int cyc;
    // reset state
    repeat (3) tick();
    check("rst_wr_en", {31'd0, fifo_wr_en_o}, 32'd0);
    check("rst_data", fifo_data_o, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_errs", {28'd0, crc_err_o, end_err_o, tout_err_o, ovr_err_o}, 32'd0);
    rst = 1'b0;
    tick();

    // 1) 4-bit, 512-byte block
    run_case1("c1");

    // 2) 8-bit, 3 x 8-byte blocks with 5-cycle start-bit gaps
    for (int i = 0; i < 8; i++) blk_data[i] = 8'(8'h10 + 7 * i);
    start_xfer(2'b10, 8, 3, 1000);
    check("c2_busy_after_start", {31'd0, busy_o}, 32'd1);
    base_done = done_count;
    send_block(2, 8, 5, 1'b0, -1, -1);
    send_block(2, 8, 5, 1'b0, -1, -1);
    check("c2_no_early_done", 32'(done_count - base_done), 32'd0);
    send_block(2, 8, 5, 1'b0, -1, -1);
    check("c2_done_at_end", {31'd0, done_o}, 32'd1);
    check("c2_busy_low", {31'd0, busy_o}, 32'd0);
    check_xfer("c2", 6, 1, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3) 1-bit, bad CRC LSB
    blk_data[0] = 8'hA5; blk_data[1] = 8'h5A; blk_data[2] = 8'h00; blk_data[3] = 8'hFF;
    start_xfer(2'b00, 4, 1, 1000);
    send_block(0, 4, 1, 1'b1, -1, -1);
    check_xfer("c3", 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("c3_word", first_word, 32'hFF005AA5);

    // 4) start-bit timeout
    start_xfer(2'b01, 16, 1, 10);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      drive(8'hFF);
      cyc++;
      if (done_count != base_done) break;
    end
    check("c4_latency_ge10", {31'd0, cyc >= 10}, 32'd1);
    check_xfer("c4", 0, 1, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5) FIFO full on the second word
    for (int i = 0; i < 16; i++) blk_data[i] = 8'(8'hC0 + i);
    start_xfer(2'b10, 16, 1, 1000);
    send_block(2, 16, 0, 1'b0, 1, -1);
    check_xfer("c5", 3, 1, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6a) abort in the middle of DATA
    start_xfer(2'b01, 512, 1, 1000);
    drive(8'hF0);
    for (int i = 0; i < 6; i++) drive(8'hF3);
    abort_i = 1'b1;
    drive(8'hF3);
    abort_i = 1'b0;
    check("c6_abort_idle", {31'd0, busy_o}, 32'd0);
    check_xfer("c6a", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6b) reset in the middle of CRC
    blk_data[0] = 8'h11; blk_data[1] = 8'h22; blk_data[2] = 8'h33; blk_data[3] = 8'h44;
    start_xfer(2'b10, 4, 1, 1000);
    send_block(2, 4, 0, 1'b0, -1, 5);
    rst = 1'b1;
    #2;
    check("c6_rst_busy", {31'd0, busy_o}, 32'd0);
    tick();
    rst = 1'b0;
    check_xfer("c6b", 1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("c6b_word", first_word, 32'h44332211);

    run_case1("c6r");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
